// File: rtl/lane_align_ctrl.sv
// lane_align_ctrl: per-lane comma hunter that drives the byte-alignment
// multiplexer select.
// It finds the lowest-index K28.5 comma in each beat and sets align so that
// comma lands on output byte 0. It then confirms the offset over several
// commas and holds the select while locked.
// Optional build macro: LANE_ALIGN_CTRL_STATS_EN adds a saturating count of
// LOCKED->HUNT transitions on realign_count. When the macro is absent, that
// port is tied to zero.
module lane_align_ctrl #(
    parameter int          DATA_PATH_WIDTH = 4,
    parameter int          CONFIRM_COUNT   = 4,
    parameter int          LOSS_COUNT      = 3,
    parameter logic [7:0]  COMMA           = 8'hBC
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         realign,
    input  logic [DATA_PATH_WIDTH*8-1:0] in_data,
    input  logic [DATA_PATH_WIDTH-1:0]   in_charisk,
    output logic [2:0]                   align,
    output logic                         locked,
    output logic [1:0]                   state,
    output logic [7:0]                   realign_count
);

    localparam int         DPW_LOG2   = (DATA_PATH_WIDTH == 8) ? 3 :
                                        (DATA_PATH_WIDTH == 4) ? 2 : 1;
    localparam logic [2:0] ALIGN_MASK = 3'((1 << DPW_LOG2) - 1);
    localparam logic [3:0] CONFIRM_N  = 4'(CONFIRM_COUNT);
    localparam logic [3:0] LOSS_N     = 4'(LOSS_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  align_reg, align_next;
    logic [3:0]  confirm_reg, confirm_next;
    logic [3:0]  miss_reg, miss_next;
    logic        locked_reg;

    logic [DATA_PATH_WIDTH-1:0] comma_flag;
    logic                       hit;
    logic [2:0]                 pos;
    logic                       match;
    logic                       mismatch;

    // A byte is a comma only when both the K flag and the data value agree.
    for (genvar gi = 0; gi < DATA_PATH_WIDTH; gi++) begin : g_comma
        assign comma_flag[gi] = in_charisk[gi] && (in_data[8*gi +: 8] == COMMA);
    end

    assign hit = |comma_flag;

    // Priority pick of the lowest comma index; later commas in the beat are ignored.
    always_comb begin
        pos = 3'd0;
        for (int k = DATA_PATH_WIDTH - 1; k >= 0; k--) begin
            if (comma_flag[k]) pos = 3'(k);
        end
    end

    assign match    = hit && (pos == align_reg);
    assign mismatch = hit && (pos != align_reg);

    // Next-state, select and counter update for the alignment FSM.
    always_comb begin
        state_next   = state_reg;
        align_next   = align_reg;
        confirm_next = confirm_reg;
        miss_next    = miss_reg;
        if (!enable) begin
            state_next   = IDLE;
            confirm_next = 4'd0;
            miss_next    = 4'd0;
        end else if (state_reg == IDLE) begin
            state_next   = HUNT;
            confirm_next = 4'd0;
            miss_next    = 4'd0;
        end else if (realign) begin
            // realign beats any comma in the same beat; align is kept until the next hit.
            state_next   = HUNT;
            confirm_next = 4'd0;
            miss_next    = 4'd0;
        end else begin
            case (state_reg)
                HUNT: begin
                    if (hit) begin
                        align_next   = pos;
                        confirm_next = 4'd1;
                        miss_next    = 4'd0;
                        state_next   = (CONFIRM_N == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        if (confirm_reg + 4'd1 >= CONFIRM_N) begin
                            confirm_next = CONFIRM_N;
                            miss_next    = 4'd0;
                            state_next   = LOCKED;
                        end else begin
                            confirm_next = confirm_reg + 4'd1;
                        end
                    end else if (mismatch) begin
                        // Re-seed on the new offset without going back through HUNT.
                        align_next   = pos;
                        confirm_next = 4'd1;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_next = 4'd0;
                    end else if (mismatch) begin
                        if (miss_reg + 4'd1 >= LOSS_N) begin
                            state_next   = HUNT;
                            confirm_next = 4'd0;
                            miss_next    = 4'd0;
                        end else begin
                            miss_next = miss_reg + 4'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, select and counter registers; locked is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            align_reg   <= 3'd0;
            confirm_reg <= 4'd0;
            miss_reg    <= 4'd0;
            locked_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            align_reg   <= align_next;
            confirm_reg <= confirm_next;
            miss_reg    <= miss_next;
            locked_reg  <= (state_next == LOCKED);
        end
    end

    assign align  = align_reg & ALIGN_MASK;
    assign locked = locked_reg;
    assign state  = state_reg;

`ifdef LANE_ALIGN_CTRL_STATS_EN
    logic [7:0] realign_count_reg;

    // Count every exit from LOCKED into HUNT, saturating at 255.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            realign_count_reg <= 8'd0;
        end else if (state_reg == LOCKED && state_next == HUNT &&
                     realign_count_reg != 8'hFF) begin
            realign_count_reg <= realign_count_reg + 8'd1;
        end
    end

    assign realign_count = realign_count_reg;
`else
    assign realign_count = 8'd0;
`endif

endmodule

// File: tb/tb_lane_align_ctrl.sv
// tb_lane_align_ctrl: table-driven check of lane_align_ctrl (DATA_PATH_WIDTH=4,
// defaults), followed by hand-written multi-cycle corner sequences.
module tb_lane_align_ctrl;

`ifdef LANE_ALIGN_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        realign = 1'b0;
    logic [31:0] in_data = 32'h44332211;
    logic [3:0]  in_charisk = 4'd0;
    logic [2:0]  align;
    logic        locked;
    logic [1:0]  state;
    logic [7:0]  realign_count;

    // Model of the external mux delay register: captures each beat at the edge.
    logic [31:0] prev_data = 32'd0;
    logic [3:0]  prev_k = 4'd0;

    int checks = 0;
    int errors = 0;

    lane_align_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .realign      (realign),
        .in_data      (in_data),
        .in_charisk   (in_charisk),
        .align        (align),
        .locked       (locked),
        .state        (state),
        .realign_count(realign_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prev_data <= in_data;
        prev_k    <= in_charisk;
    end

    typedef struct {
        logic       rstn;
        logic       en;
        logic       ra;
        int         kind;
        logic [2:0] e_align;
        logic       e_locked;
        logic [1:0] e_state;
        logic [7:0] e_rc;
        logic       mux;
    } vec_t;

    vec_t tbl[$];

    // kind: -1 none, 0..3 comma at that byte, 10 BC without K, 11 K non-comma, 13 commas at bytes 1 and 3
    function automatic logic [31:0] beat_data(int kind);
        logic [31:0] d;
        d = 32'h44332211;
        if (kind >= 0 && kind <= 3) d[8*kind +: 8] = 8'hBC;
        else if (kind == 10) d[15:8] = 8'hBC;
        else if (kind == 11) d[15:8] = 8'h1C;
        else if (kind == 13) begin
            d[15:8]  = 8'hBC;
            d[31:24] = 8'hBC;
        end
        return d;
    endfunction

    function automatic logic [3:0] beat_k(int kind);
        logic [3:0] k;
        k = 4'd0;
        if (kind >= 0 && kind <= 3) k[kind] = 1'b1;
        else if (kind == 11) k = 4'b0010;
        else if (kind == 13) k = 4'b1010;
        return k;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic rstn, input logic en, input logic ra, input int kind);
        resetn     = rstn;
        enable     = en;
        realign    = ra;
        in_data    = beat_data(kind);
        in_charisk = beat_k(kind);
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string name, input int e_align, input int e_locked, input int e_state);
        chk({name, ".align"},  int'(align),  e_align);
        chk({name, ".locked"}, int'(locked), e_locked);
        chk({name, ".state"},  int'(state),  e_state);
        $display("txn %s align=%0d locked=%0d state=%0d rc=%0d",
                 name, align, locked, state, realign_count);
    endtask

    task automatic add(input logic rstn, input logic en, input logic ra, input int kind,
                       input int ea, input int el, input int es, input int erc, input logic mx);
        vec_t v;
        v.rstn = rstn; v.en = en; v.ra = ra; v.kind = kind;
        v.e_align = 3'(ea); v.e_locked = el[0]; v.e_state = 2'(es);
        v.e_rc = 8'(erc); v.mux = mx;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lock at byte 2, then loss, then re-acquire at byte 1.
        add(0, 0, 0, -1, 0, 0, 0, 0, 0);
        add(1, 0, 0, -1, 0, 0, 0, 0, 0);
        add(1, 1, 0,  2, 0, 0, 1, 0, 0);   // IDLE->HUNT, comma ignored
        add(1, 1, 0, -1, 0, 0, 1, 0, 0);
        add(1, 1, 0,  2, 2, 0, 2, 0, 1);   // first comma: align=2, confirm 1
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 3; i++) add(1, 1, 0, -1, 2, 0, 2, 0, 0);
            if (c < 2) add(1, 1, 0, 2, 2, 0, 2, 0, 1);
            else       add(1, 1, 0, 2, 2, 1, 3, 0, 1); // 4th comma locks
        end
        add(1, 1, 0, 10, 2, 1, 3, 0, 0);   // BC without K is not a comma
        add(1, 1, 0, 11, 2, 1, 3, 0, 0);   // K other than BC is not a comma
        add(1, 1, 0,  1, 2, 1, 3, 0, 0);   // miss 1
        add(1, 1, 0,  1, 2, 1, 3, 0, 0);   // miss 2
        add(1, 1, 0,  2, 2, 1, 3, 0, 1);   // match clears misses
        add(1, 1, 0,  1, 2, 1, 3, 0, 0);   // miss 1
        add(1, 1, 0,  1, 2, 1, 3, 0, 0);   // miss 2
        add(1, 1, 0, -1, 2, 1, 3, 0, 0);   // no comma: miss count kept
        add(1, 1, 0,  1, 2, 0, 1, 1, 0);   // miss 3: HUNT
        add(1, 1, 0, -1, 2, 0, 1, 1, 0);
        add(1, 1, 0, 11, 2, 0, 1, 1, 0);
        add(1, 1, 0,  1, 1, 0, 2, 1, 1);   // re-acquire at byte 1
        add(1, 0, 0,  2, 1, 0, 0, 1, 0);   // enable low: IDLE, align held

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            apply(tbl[i].rstn, tbl[i].en, tbl[i].ra, tbl[i].kind);
            expect3(nm, int'(tbl[i].e_align), int'(tbl[i].e_locked), int'(tbl[i].e_state));
            chk({nm, ".rc"}, int'(realign_count), STATS ? int'(tbl[i].e_rc) : 0);
            if (tbl[i].mux) begin
                logic [7:0] b0;
                b0 = prev_data[8*align +: 8];
                chk({nm, ".mux_b0"}, int'(b0), 8'hBC);
                chk({nm, ".mux_k0"}, int'(prev_k[align]), 1);
            end
        end

        // VERIFY re-seed: confirm=2 at align 3, then a byte-0 comma.
        apply(0, 1, 0, -1); expect3("A.rst", 0, 0, 0);
        apply(1, 1, 0, -1); expect3("A.hunt", 0, 0, 1);
        apply(1, 1, 0, 3);  expect3("A.c1", 3, 0, 2);
        apply(1, 1, 0, 3);  expect3("A.c2", 3, 0, 2);
        apply(1, 1, 0, 0);  expect3("A.reseed", 0, 0, 2);
        apply(1, 1, 0, 0);  expect3("A.m2", 0, 0, 2);
        apply(1, 1, 0, 0);  expect3("A.m3", 0, 0, 2);
        apply(1, 1, 0, 0);  expect3("A.lock", 0, 1, 3);

        // Two commas in one beat while hunting: lowest index wins.
        apply(0, 1, 0, -1); expect3("B.rst", 0, 0, 0);
        apply(1, 1, 0, -1); expect3("B.hunt", 0, 0, 1);
        apply(1, 1, 0, 13); expect3("B.multi", 1, 0, 2);

        // Same-cycle realign and comma while LOCKED.
        apply(0, 1, 0, -1); expect3("C.rst", 0, 0, 0);
        chk("C.rst.rc", int'(realign_count), 0);
        apply(1, 1, 0, -1); expect3("C.hunt", 0, 0, 1);
        for (int i = 0; i < 3; i++) apply(1, 1, 0, 3);
        apply(1, 1, 0, 3);  expect3("C.lock", 3, 1, 3);
        apply(1, 1, 1, 0);  expect3("C.realign", 3, 0, 1);
        chk("C.realign.rc", int'(realign_count), STATS ? 1 : 0);
        apply(1, 1, 0, -1); expect3("C.after", 3, 0, 1);
        for (int i = 0; i < 3; i++) apply(1, 1, 0, 3);
        apply(1, 1, 0, 3);  expect3("C.relock", 3, 1, 3);

        // One-cycle reset while LOCKED with enable high.
        apply(0, 1, 0, 3);  expect3("D.rst", 0, 0, 0);
        chk("D.rst.rc", int'(realign_count), 0);
        apply(1, 1, 0, -1); expect3("D.hunt", 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_align_ctrl.md
# lane_align_ctrl

Per-lane alignment controller for the JESD204 RX byte-alignment multiplexer. It watches the same beat stream that feeds the multiplexer and hunts for K28.5 comma characters. It then drives the multiplexer's 3-bit `align` select so that the comma lands on output byte 0, confirms the offset over several commas, and holds the select while locked. It sits between the lane's 8b/10b decoder output and the align multiplexer, one instance per lane.

## Interface

Parameters:
- `DATA_PATH_WIDTH`, 4, bytes per beat; legal values are 2, 4 and 8. `DPW_LOG2` is 1, 2 or 3 respectively.
- `CONFIRM_COUNT`, 4, number of consecutive same-offset commas (including the first) needed to lock; range 1..15.
- `LOSS_COUNT`, 3, number of consecutive wrong-offset commas that drops lock; range 1..15.
- `COMMA`, 8'hBC, data byte which, together with charisk=1, counts as a comma.

Ports:
- `clk` input 1: the lane clock. All logic is on its rising edge.
- `resetn` input 1: reset, synchronous and active-low.
- `enable` input 1: when low, forces state IDLE.
- `realign` input 1: single-cycle request; forces HUNT from any non-IDLE state.
- `in_data` input DATA_PATH_WIDTH*8: the beat also presented to the multiplexer.
- `in_charisk` input DATA_PATH_WIDTH: per-byte K flags.
- `align` output 3: multiplexer select. Registered. Bits above DPW_LOG2-1 are always 0.
- `locked` output 1: registered; high only in state LOCKED.
- `state` output 2: current state (IDLE=0, HUNT=1, VERIFY=2, LOCKED=3).
- `realign_count` output 8: see Configuration.

## Operation

- Per-beat comma detect: byte `k` is a comma when `in_charisk[k]` is high and `in_data[8k+7:8k]` equals `COMMA`.
  - `hit` is the OR of all byte comma flags.
  - `pos` is the lowest index with a comma. Higher-index commas in the same beat are ignored.
- Offset rule: `align = pos`. When the comma shifts into the multiplexer's delayed half, this places it at output byte 0.
- `match` means `hit` and `pos == align`. `mismatch` means `hit` and `pos != align`. A beat with no comma changes nothing.
- IDLE:
  - Entered on reset or whenever `enable` is low, which takes priority over everything except `resetn`.
  - `align` holds its value. Counters are cleared.
  - Goes to HUNT when `enable` is high.
- HUNT:
  - On `hit`: `align <= pos`, confirm counter `<= 1`, then go to VERIFY, or directly to LOCKED if `CONFIRM_COUNT == 1`.
- VERIFY:
  - `match` increments the confirm counter. On reaching `CONFIRM_COUNT`, go to LOCKED and clear the miss counter.
  - `mismatch`: `align <= pos`, confirm counter `<= 1`, stay in VERIFY. This is an immediate re-seed, with no pass through HUNT.
- LOCKED:
  - `align` is frozen.
  - `match` clears the miss counter.
  - `mismatch` increments the miss counter. On reaching `LOSS_COUNT`, go to HUNT.
  - Beats without a comma leave the miss counter unchanged, so misses are consecutive-among-commas, not per-beat.
- `realign` high while in HUNT, VERIFY or LOCKED:
  - Next state is HUNT and counters are cleared. `align` holds until the next `hit` in HUNT.
  - If `realign` and `hit` occur in the same cycle, `realign` wins and the comma is discarded.
- Counters are 4 bits wide and never wrap; they saturate at the parameter value.

## Timing

- Reset values: `align`=0, `locked`=0, `state`=IDLE, confirm and miss counters 0, `realign_count`=0.
- Reset is honoured on any cycle, including mid-VERIFY or LOCKED. The reset values appear at the edge where `resetn` is sampled low.
- Detect-to-select latency is 0 beats at the multiplexer output.
  - A comma sampled on `in_data` at edge n sets `align` at edge n. That is the same edge at which the multiplexer's delay register captures that beat.
  - The comma therefore appears at output byte 0 in the cycle after edge n.
- `locked` rises at the edge that samples the `CONFIRM_COUNT`-th matching comma.
- `locked` falls at the edge that samples the `LOSS_COUNT`-th consecutive mismatch, or at the edge where `realign`, `!enable` or `!resetn` is sampled.
- Inputs need no registering; detection is combinational on `in_data` and `in_charisk`.

## Configuration

- `LANE_ALIGN_CTRL_STATS_EN` defined:
  - `realign_count` is an 8-bit counter that saturates at 255.
  - It increments on every transition from LOCKED to HUNT, whether caused by loss or by `realign`.
  - It is cleared only by `resetn`.
- Macro undefined: `realign_count` is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan

- Defaults, DATA_PATH_WIDTH=4, with a K28.5 every 4th beat at byte 2:
  - `align` becomes 2 on the first comma edge.
  - `locked` rises on the 4th comma.
  - The multiplexer output shows 8'hBC at byte 0 with charisk[0]=1.
- LOCKED at `align`=2; then 2 commas at byte 1, 1 at byte 2, and 3 at byte 1:
  - `locked` stays high through the first 2 misses, because the byte-2 comma clears the miss counter.
  - `locked` drops on the 3rd consecutive miss and `state` becomes HUNT.
  - The next comma sets `align`=1.
- VERIFY with confirm=2 at `align`=3, then a comma at byte 0:
  - `align` becomes 0 and confirm becomes 1.
  - 3 further byte-0 commas are needed to lock.
- Beat with commas at bytes 1 and 3 while in HUNT: `align`=1.
- Same-cycle `realign` and comma while LOCKED:
  - `state`=HUNT, `align` unchanged, `locked`=0.
  - With the macro defined, `realign_count` increments to 1.
- `resetn` low for one cycle while LOCKED with `align`=3, `enable` high:
  - Next cycle: `align`=0, `locked`=0, `state`=IDLE.
  - The cycle after: HUNT.
